// File: rtl/accel_driver.sv
// Bus initiator for the matrix-multiply accelerator: streams A then B into the
// accelerator windows, waits for both stored flags, then reads C out as a stream.
module accel_driver #(
  parameter int                    BITS       = 8,
  parameter int                    N          = 8,
  parameter int                    WIDTH      = 4,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] OFFCET     = 10'd128,
  parameter int                    TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [WIDTH*BITS-1:0]   src_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH*BITS-1:0]   res_data,
  output logic                    res_last,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic                    bus_wr_en,
  output logic [WIDTH*BITS-1:0]   bus_wdata,
  input  logic [WIDTH*BITS-1:0]   bus_rdata,
  input  logic                    a_stored,
  input  logic                    b_stored,
  input  logic                    c_show
);

  localparam int DW        = WIDTH * BITS;
  localparam int STEP      = DW / 8;
  localparam int WORDS     = N * N / WIDTH;
  localparam int MAT_BYTES = N * N * BITS / 8;
  localparam int CW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TW        = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] A_BASE = OFFCET;
  localparam logic [ADDR_WIDTH-1:0] B_BASE = OFFCET + ADDR_WIDTH'(MAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] C_BASE = B_BASE + ADDR_WIDTH'(MAT_BYTES);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, WAIT_ST, READ_C, DRAIN, FIN
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                  bus_wr_en_q, bus_wr_en_d;
  logic [DW-1:0]         bus_wdata_q, bus_wdata_d;
  logic [DW-1:0]         res_data_q, res_data_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_last_q, res_last_d;
  logic                  error_q, error_d;

  logic                  cnt_last;
  logic [ADDR_WIDTH-1:0] win_base;

  assign cnt_last = (cnt_q == CW'(WORDS - 1));
  assign win_base = (state_q == LOAD_A) ? A_BASE : B_BASE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      bus_addr_q  <= '0;
      bus_wr_en_q <= 1'b0;
      bus_wdata_q <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      bus_addr_q  <= bus_addr_d;
      bus_wr_en_q <= bus_wr_en_d;
      bus_wdata_q <= bus_wdata_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    bus_addr_d  = bus_addr_q;
    bus_wr_en_d = 1'b0;
    bus_wdata_d = bus_wdata_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_last_d  = res_last_q;
    error_d     = error_q;
    src_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        bus_addr_d = '0;
        if (start) begin
          error_d = 1'b0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = LOAD_A;
        end
      end
      LOAD_A, LOAD_B: begin
        src_ready = 1'b1;
        if (src_valid) begin
          bus_wdata_d = src_data;
          bus_wr_en_d = 1'b1;
          bus_addr_d  = win_base + ADDR_WIDTH'(cnt_q) * STEP_A;
          if (cnt_last) begin
            cnt_d   = '0;
            timer_d = '0;
            state_d = (state_q == LOAD_A) ? LOAD_B : WAIT_ST;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_ST: begin
        // Flags win over an expiring timer in the same cycle.
        if (a_stored && b_stored) begin
          bus_addr_d = C_BASE;
          cnt_d      = '0;
          state_d    = READ_C;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = FIN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      READ_C: begin
        if (!res_valid_q || res_ready) begin
          if (!c_show) begin
            error_d     = 1'b1;
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            state_d     = FIN;
          end else begin
            res_data_d  = bus_rdata;
            res_valid_d = 1'b1;
            res_last_d  = cnt_last;
            bus_addr_d  = bus_addr_q + STEP_A;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_last) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          state_d     = FIN;
        end
      end
      FIN: begin
        bus_addr_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign error     = error_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_last  = res_last_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wr_en = bus_wr_en_q;
  assign bus_wdata = bus_wdata_q;

endmodule
